reg_bank: RTL and testbench
===========================

# reg_bank

Synchronous-write, asynchronous-read register bank of 32 words × 32 bits. It has two independent read ports and one write port. It serves as the general-purpose register file of a simple datapath. Source registers are read combinationally; the destination register is written on the rising clock edge.

## Interface
- DATA_W, 32, word width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W (32).

- clk  input  1  single system clock; all writes occur on its rising edge.
- reset  input  1  asynchronous, active-low reset; clears every register to 0.
- rdData1  output  DATA_W  contents of register addressed by sr1.
- rdData2  output  DATA_W  contents of register addressed by sr2.
- wrData  input  DATA_W  data to be written to register dr.
- sr1  input  ADDR_W  read address, port 1.
- sr2  input  ADDR_W  read address, port 2.
- dr  input  ADDR_W  write (destination) address.
- write  input  1  write enable, active high.
- Positional port order is fixed: rdData1, rdData2, wrData, sr1, sr2, dr, write, reset, clk.

## Operation
- Storage: 32 independent DATA_W-bit registers, indices 0..31.
- All 32 registers are writable, including register 0. There is no hard-wired zero.
- Write: on the rising edge of clk, with reset high and write = 1, regs[dr] <= wrData. No other register changes.
- write = 0 at the edge: no register changes, regardless of dr and wrData.
- Read: rdData1 = regs[sr1] and rdData2 = regs[sr2]. Both are purely combinational from the stored array.
- Both read ports may address the same register. Either port may equal dr.
- There is no write-to-read bypass. A read of dr returns the old value until the write edge, then the new value.
- Reset: while reset = 0, all registers are forced to 0 immediately, independent of clk. Reset overrides write.
- Out-of-range addresses cannot occur, since the full ADDR_W space is populated.

## Timing
- Write latency: 1 clock edge. New data is visible on the read outputs combinationally after that edge.
- Read latency: 0 cycles, combinational from sr1/sr2 and register state.
- Output value during and immediately after reset: rdData1 = rdData2 = 0 for any addresses.
- Reset assertion mid-operation clears all registers asynchronously. A write coincident with reset is discarded.
- Reset deassertion: the first write takes effect on the first rising edge after reset returns high.
- Inputs sr1, sr2, dr, wrData and write must be stable around the rising edge (standard setup/hold). There is no handshake.

## Structure
- Shared package: DATA_W = 32, ADDR_W = 5, NUM_REGS = 32, and a word typedef of DATA_W bits.
- One natural sub-module, reg_bank_word: a single DATA_W register with async active-low clear and load enable.
  - reg_bank instantiates 32 of these.
  - A one-hot write-enable decode of dr gated by write drives the load enables.
  - Two 32:1 read multiplexers drive rdData1 and rdData2.

## Test plan
- Reset: hold reset = 0 for 5 ns with write = 0, then release. Sweep sr1 and sr2 over 0..31; every read returns 0.
- Fill: for j = 0..31, set dr = j, wrData = 10*j, write = 1 for one edge. Then read pairs sr1 = k, sr2 = k+1 for even k.
  - Expect reg[k] = 10k and reg[k+1] = 10k+10.
  - Spot checks: reg[0] = 0, reg[1] = 10, reg[30] = 300, reg[31] = 310.
- Write disable: set write = 0, dr = 5, wrData = 999 and clock several edges. reg[5] stays 50.
- Same-address read/write: set sr1 = sr2 = dr = 7, wrData = 0xDEADBEEF, write = 1.
  - Before the edge, both ports read 70.
  - After the edge, both ports read 0xDEADBEEF.
- Async reset mid-operation: after the fill, drop reset between clock edges. Both outputs go to 0 immediately, without waiting for a clock edge.
  - A concurrent write to reg 3 is discarded; reg[3] reads 0 after release.
- Register 0 writable: write 0x12345678 to dr = 0. Reading sr1 = 0 returns 0x12345678.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared sizing constants and word type for the register bank.
//   DATA_W   - word width in bits
//   ADDR_W   - register address width
//   NUM_REGS - number of registers (2**ADDR_W)
package reg_bank_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned NUM_REGS = 2 ** ADDR_W;

   typedef logic [DATA_W-1:0] word_t;

endpackage : reg_bank_pkg

// File: rtl/reg_bank_word.sv
// reg_bank_word: one storage word of the register bank.
//   clk   - write clock (rising edge)
//   reset - asynchronous active-low clear
//   load  - load enable; captures d on the rising edge when high
//   d     - data to load
//   q     - stored word
module reg_bank_word
   import reg_bank_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] word_d;
   logic [WIDTH-1:0] word_q;

   always_comb begin
      word_d = word_q;
      if (load) begin
         word_d = d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word_q <= '0;
      end else begin
         word_q <= word_d;
      end
   end

   assign q = word_q;

endmodule : reg_bank_word

// File: rtl/reg_bank.sv
// reg_bank: 2-read / 1-write register file, synchronous write, combinational read.
//   rdData1 - contents of register sr1
//   rdData2 - contents of register sr2
//   wrData  - data written to register dr
//   sr1/sr2 - read addresses
//   dr      - write address
//   write   - write enable (active high)
//   reset   - asynchronous active-low clear of every register
//   clk     - write clock (rising edge)
// Every register, including register 0, is writable; reads of dr return the
// old value until the write edge (no bypass).
module reg_bank #(
   parameter int unsigned DATA_W = reg_bank_pkg::DATA_W,
   parameter int unsigned ADDR_W = reg_bank_pkg::ADDR_W
) (
   output logic [DATA_W-1:0] rdData1,
   output logic [DATA_W-1:0] rdData2,
   input  logic [DATA_W-1:0] wrData,
   input  logic [ADDR_W-1:0] sr1,
   input  logic [ADDR_W-1:0] sr2,
   input  logic [ADDR_W-1:0] dr,
   input  logic              write,
   input  logic              reset,
   input  logic              clk
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DEPTH-1:0]  load;
   logic [DATA_W-1:0] regs [DEPTH];

   // One-hot decode of the destination address, gated by the write enable.
   always_comb begin
      load = '0;
      if (write) begin
         load[dr] = 1'b1;
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      reg_bank_word #(
         .WIDTH (DATA_W)
      ) u_word (
         .clk   (clk),
         .reset (reset),
         .load  (load[i]),
         .d     (wrData),
         .q     (regs[i])
      );
   end

   always_comb begin
      rdData1 = regs[sr1];
      rdData2 = regs[sr2];
   end

endmodule : reg_bank

// File: tb/tb_reg_bank.sv
// tb_reg_bank: self-checking bench for reg_bank against an array model.
module tb_reg_bank;
   import reg_bank_pkg::*;

   logic            clk;
   logic            reset;
   logic            write;
   logic [ADDR_W-1:0] sr1, sr2, dr;
   word_t           wrData;
   word_t           rdData1, rdData2;

   word_t           mdl [NUM_REGS];
   int unsigned     n_tests;
   int unsigned     n_fail;

   reg_bank #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .rdData1 (rdData1),
      .rdData2 (rdData2),
      .wrData  (wrData),
      .sr1     (sr1),
      .sr2     (sr2),
      .dr      (dr),
      .write   (write),
      .reset   (reset),
      .clk     (clk)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input word_t got, input word_t exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
   endtask

   // Drive at the falling edge, let the rising edge write, sample 1 ns later.
   task automatic do_write(input int unsigned a, input word_t data, input logic we);
      @(negedge clk);
      dr     = ADDR_W'(a);
      wrData = data;
      write  = we;
      @(posedge clk);
      if (we && reset) mdl[a] = data;
      #1;
      write = 1'b0;
   endtask

   task automatic check_ports(input string tag);
      #1;
      check({tag, "_rd1"}, rdData1, mdl[sr1]);
      check({tag, "_rd2"}, rdData2, mdl[sr2]);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b0;
      write   = 1'b0;
      sr1     = '0;
      sr2     = '0;
      dr      = '0;
      wrData  = '0;
      model_clear();

      // Reset: hold low, release between edges, every register reads 0.
      #7;
      reset = 1'b1;
      for (int i = 0; i < NUM_REGS; i++) begin
         sr1 = ADDR_W'(i);
         sr2 = ADDR_W'(NUM_REGS - 1 - i);
         #1;
         check("reset_rd1", rdData1, '0);
         check("reset_rd2", rdData2, '0);
      end

      // Fill every register with 10*j.
      for (int j = 0; j < NUM_REGS; j++) do_write(j, word_t'(10 * j), 1'b1);
      for (int k = 0; k < NUM_REGS; k += 2) begin
         sr1 = ADDR_W'(k);
         sr2 = ADDR_W'(k + 1);
         #1;
         check("fill_even", rdData1, word_t'(10 * k));
         check("fill_odd",  rdData2, word_t'(10 * k + 10));
      end
      sr1 = 5'd0;  sr2 = 5'd1;  #1;
      check("spot_r0", rdData1, 32'd0);
      check("spot_r1", rdData2, 32'd10);
      sr1 = 5'd30; sr2 = 5'd31; #1;
      check("spot_r30", rdData1, 32'd300);
      check("spot_r31", rdData2, 32'd310);

      // Write disabled: several edges with write low leave reg 5 alone.
      for (int i = 0; i < 4; i++) do_write(5, 32'd999, 1'b0);
      sr1 = 5'd5; sr2 = 5'd5; #1;
      check("wr_dis_r5", rdData1, 32'd50);

      // Same-address read/write: old value before the edge, new after.
      @(negedge clk);
      sr1 = 5'd7; sr2 = 5'd7; dr = 5'd7; wrData = 32'hDEADBEEF; write = 1'b1;
      #1;
      check("same_pre_rd1", rdData1, 32'd70);
      check("same_pre_rd2", rdData2, 32'd70);
      @(posedge clk);
      mdl[7] = 32'hDEADBEEF;
      #1;
      write = 1'b0;
      check("same_post_rd1", rdData1, 32'hDEADBEEF);
      check("same_post_rd2", rdData2, 32'hDEADBEEF);

      // Register 0 is writable.
      do_write(0, 32'h12345678, 1'b1);
      sr1 = 5'd0; #1;
      check("r0_write", rdData1, 32'h12345678);

      // Randomized traffic, with occasional async resets between edges.
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         sr1    = ADDR_W'($urandom_range(NUM_REGS - 1));
         sr2    = ($urandom_range(7) == 0) ? sr1 : ADDR_W'($urandom_range(NUM_REGS - 1));
         dr     = ($urandom_range(3) == 0) ? sr1 : ADDR_W'($urandom_range(NUM_REGS - 1));
         wrData = $urandom;
         write  = ($urandom_range(3) != 0);
         check_ports("rnd_pre");
         if ($urandom_range(31) == 0) begin
            #1;
            reset = 1'b0;
            model_clear();
            check_ports("rnd_rst");
            reset = 1'b1;
         end
         @(posedge clk);
         if (write) mdl[dr] = wrData;
         check_ports("rnd_post");
      end

      // Async reset mid-operation, with a concurrent write to reg 3 discarded.
      for (int j = 0; j < NUM_REGS; j++) do_write(j, word_t'(10 * j), 1'b1);
      @(negedge clk);
      sr1 = 5'd3; sr2 = 5'd9; dr = 5'd3; wrData = 32'h0000ABCD; write = 1'b1;
      #1;
      check("pre_rst_r3", rdData1, 32'd30);
      check("pre_rst_r9", rdData2, 32'd90);
      #1;
      reset = 1'b0;
      #1;
      check("async_rst_rd1", rdData1, '0);
      check("async_rst_rd2", rdData2, '0);
      @(posedge clk);
      #2;
      write = 1'b0;
      reset = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
      check("rst_discard_r3", rdData1, '0);
      check("rst_discard_r9", rdData2, '0);

      // First write after release lands on the next edge.
      do_write(3, 32'h0BADF00D, 1'b1);
      sr1 = 5'd3; sr2 = 5'd31; #1;
      check("post_rst_wr_r3", rdData1, 32'h0BADF00D);
      check("post_rst_r31",   rdData2, '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule : tb_reg_bank
